// File: rtl/regpair_sequencer_pkg.sv
// Shared register-file constants: 8-bit register selects plus the 16-bit
// pair and operation encodings used by the pair sequencer.
package regpair_sequencer_pkg;

  typedef enum logic [2:0] {
    REG_B = 3'd0,
    REG_C = 3'd1,
    REG_D = 3'd2,
    REG_E = 3'd3,
    REG_H = 3'd4,
    REG_L = 3'd5,
    REG_F = 3'd6,
    REG_A = 3'd7
  } reg_sel_t;

  typedef enum logic [1:0] {
    PAIR_BC = 2'd0,
    PAIR_DE = 2'd1,
    PAIR_HL = 2'd2
  } pair_sel_t;

  typedef enum logic [1:0] {
    OP_LOAD16 = 2'd0,
    OP_READ16 = 2'd1,
    OP_INC16  = 2'd2,
    OP_DEC16  = 2'd3
  } op16_t;

endpackage

// File: rtl/regpair_sequencer.sv
// Sequences 16-bit pair load/read/inc/dec over the 8-bit single-write-port
// register file, owning its control lines while an operation is in flight.
module regpair_sequencer
  import regpair_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [1:0]  req_pair,
  input  logic [15:0] req_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        rf_own,
  output logic        rf_load_en,
  output reg_sel_t    rf_sel_a,
  output reg_sel_t    rf_sel_b,
  output logic [7:0]  rf_wdata,
  input  logic [7:0]  rf_out_a,
  input  logic [7:0]  rf_out_b
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    WR_LO = 3'd2,
    WR_HI = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  op16_t       op_q, op_d;
  logic [1:0]  pair_q, pair_d;
  logic [15:0] val_q, val_d;
  logic        err_q, err_d;
  logic [15:0] rsp_data_q, rsp_data_d;

  reg_sel_t    hi_sel, lo_sel;
  logic [15:0] rd_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= OP_LOAD16;
      pair_q     <= '0;
      val_q      <= '0;
      err_q      <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      pair_q     <= pair_d;
      val_q      <= val_d;
      err_q      <= err_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    pair_d     = pair_q;
    val_d      = val_q;
    err_d      = err_q;
    rsp_data_d = rsp_data_q;

    req_ready  = 1'b0;
    busy       = 1'b1;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    rf_own     = 1'b0;
    rf_load_en = 1'b0;
    rf_sel_a   = REG_A;
    rf_sel_b   = REG_A;
    rf_wdata   = '0;
    rd_val     = {rf_out_a, rf_out_b};

    case (pair_q)
      PAIR_BC: begin hi_sel = REG_B; lo_sel = REG_C; end
      PAIR_DE: begin hi_sel = REG_D; lo_sel = REG_E; end
      PAIR_HL: begin hi_sel = REG_H; lo_sel = REG_L; end
      default: begin hi_sel = REG_A; lo_sel = REG_A; end
    endcase

    // rsp_data is loaded on the transition into DONE so it stays stable
    // until the next response, independent of later captures into val.
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          op_d   = op16_t'(req_op);
          pair_d = req_pair;
          if (req_pair == 2'b11) begin
            err_d      = 1'b1;
            val_d      = '0;
            rsp_data_d = '0;
            state_d    = DONE;
          end else begin
            err_d = 1'b0;
            if (op16_t'(req_op) == OP_LOAD16) begin
              val_d   = req_data;
              state_d = WR_LO;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD: begin
        rf_own   = 1'b1;
        rf_sel_a = hi_sel;
        rf_sel_b = lo_sel;
        case (op_q)
          OP_INC16: begin val_d = rd_val + 16'd1; state_d = WR_LO; end
          OP_DEC16: begin val_d = rd_val - 16'd1; state_d = WR_LO; end
          default: begin
            val_d      = rd_val;
            rsp_data_d = rd_val;
            state_d    = DONE;
          end
        endcase
      end
      WR_LO: begin
        rf_own     = 1'b1;
        rf_load_en = 1'b1;
        rf_sel_a   = lo_sel;
        rf_wdata   = val_q[7:0];
        state_d    = WR_HI;
      end
      WR_HI: begin
        rf_own     = 1'b1;
        rf_load_en = 1'b1;
        rf_sel_a   = hi_sel;
        rf_wdata   = val_q[15:8];
        rsp_data_d = val_q;
        state_d    = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_regpair_sequencer.sv
// Self-checking bench: register-file model, directed vector table, reset
// abort sequence and randomized transactions against a pair-level model.
module tb_regpair_sequencer;
  import regpair_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [1:0]  req_pair;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        rf_own;
  logic        rf_load_en;
  reg_sel_t    rf_sel_a;
  reg_sel_t    rf_sel_b;
  logic [7:0]  rf_wdata;
  logic [7:0]  rf_out_a;
  logic [7:0]  rf_out_b;

  int vectors = 0;
  int miscompares = 0;

  // Register file: B C D E H L F A; not touched by rst.
  logic [7:0] rf [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h3C};

  always #5 clk = ~clk;

  always @(posedge clk) if (rf_load_en) rf[rf_sel_a] <= rf_wdata;
  assign rf_out_a = rf[rf_sel_a];
  assign rf_out_b = rf[rf_sel_b];

  regpair_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_pair(req_pair), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .rf_own(rf_own), .rf_load_en(rf_load_en),
    .rf_sel_a(rf_sel_a), .rf_sel_b(rf_sel_b), .rf_wdata(rf_wdata),
    .rf_out_a(rf_out_a), .rf_out_b(rf_out_b)
  );

  // Pair-level model: 16-bit values of BC, DE, HL.
  logic [15:0] pv [3];

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  pair;
    logic [15:0] data;
    logic [15:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_loads;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] rf_pair(input int p);
    case (p)
      0:       return {rf[0], rf[1]};
      1:       return {rf[2], rf[3]};
      default: return {rf[4], rf[5]};
    endcase
  endfunction

  task automatic check_regs();
    chk("pair BC", 32'(rf_pair(0)), 32'(pv[0]));
    chk("pair DE", 32'(rf_pair(1)), 32'(pv[1]));
    chk("pair HL", 32'(rf_pair(2)), 32'(pv[2]));
    chk("reg F",   32'(rf[6]), 32'h A5);
    chk("reg A",   32'(rf[7]), 32'h 3C);
  endtask

  // Called and returns at a negedge; junk is driven on req_* while busy.
  task automatic txn(input logic [1:0] op, input logic [1:0] pr, input logic [15:0] d,
                     output logic [15:0] rd, output logic er, output int lat, output int loads);
    int k;
    k = 0;
    while (!req_ready && k < 10) begin @(negedge clk); k++; end
    req_valid = 1'b1; req_op = op; req_pair = pr; req_data = d;
    @(posedge clk);
    lat = 0; loads = 0; rd = '0; er = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) chk("busy after accept", 32'(busy), 32'd1);
      req_op = 2'($urandom); req_pair = 2'($urandom); req_data = 16'($urandom);
      if (rf_load_en) loads++;
      if (rsp_valid) begin
        lat = c; rd = rsp_data; er = rsp_err; req_valid = 1'b0;
        break;
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  // Applies one request, checks response against expectations, updates model.
  task automatic run_one(input vec_t v);
    logic [15:0] rd;
    logic        er;
    int          lat, loads;
    txn(v.op, v.pair, v.data, rd, er, lat, loads);
    chk("rsp latency", 32'(lat), 32'(v.exp_lat));
    chk("rsp_data", 32'(rd), 32'(v.exp_data));
    chk("rsp_err", 32'(er), 32'(v.exp_err));
    chk("load_en cycles", 32'(loads), 32'(v.exp_loads));
    chk("req_ready after done", 32'(req_ready), 32'd1);
    chk("rsp_data held", 32'(rsp_data), 32'(v.exp_data));
    if (!v.exp_err && v.op != 2'(OP_READ16)) pv[v.pair] = v.exp_data;
    check_regs();
  endtask

  function automatic vec_t model(input logic [1:0] op, input logic [1:0] pr, input logic [15:0] d);
    vec_t v;
    v.op = op; v.pair = pr; v.data = d;
    if (pr == 2'b11) begin
      v.exp_data = '0; v.exp_err = 1'b1; v.exp_lat = 1; v.exp_loads = 0;
    end else begin
      v.exp_err = 1'b0;
      case (op)
        2'(OP_LOAD16): begin v.exp_data = d;              v.exp_lat = 3; v.exp_loads = 2; end
        2'(OP_READ16): begin v.exp_data = pv[pr];         v.exp_lat = 2; v.exp_loads = 0; end
        2'(OP_INC16):  begin v.exp_data = pv[pr] + 16'd1; v.exp_lat = 4; v.exp_loads = 2; end
        default:       begin v.exp_data = pv[pr] - 16'd1; v.exp_lat = 4; v.exp_loads = 2; end
      endcase
    end
    return v;
  endfunction

  initial begin
    vec_t tbl [9];
    int   seen;
    tbl[0] = '{2'(OP_LOAD16), 2'(PAIR_HL), 16'hBEEF, 16'hBEEF, 1'b0, 3, 2};
    tbl[1] = '{2'(OP_LOAD16), 2'(PAIR_BC), 16'h12FF, 16'h12FF, 1'b0, 3, 2};
    tbl[2] = '{2'(OP_INC16),  2'(PAIR_BC), 16'h0000, 16'h1300, 1'b0, 4, 2};
    tbl[3] = '{2'(OP_LOAD16), 2'(PAIR_DE), 16'hFFFF, 16'hFFFF, 1'b0, 3, 2};
    tbl[4] = '{2'(OP_INC16),  2'(PAIR_DE), 16'h1234, 16'h0000, 1'b0, 4, 2};
    tbl[5] = '{2'(OP_DEC16),  2'(PAIR_DE), 16'h0000, 16'hFFFF, 1'b0, 4, 2};
    tbl[6] = '{2'(OP_LOAD16), 2'(PAIR_HL), 16'h8001, 16'h8001, 1'b0, 3, 2};
    tbl[7] = '{2'(OP_READ16), 2'(PAIR_HL), 16'h5555, 16'h8001, 1'b0, 2, 0};
    tbl[8] = '{2'(OP_LOAD16), 2'b11,       16'h1234, 16'h0000, 1'b1, 1, 0};
    pv[0] = '0; pv[1] = '0; pv[2] = '0;

    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_pair = '0; req_data = '0;
    repeat (2) @(negedge clk);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_data", 32'(rsp_data), 32'd0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset rf_own", 32'(rf_own), 32'd0);
    chk("reset rf_load_en", 32'(rf_load_en), 32'd0);
    chk("reset rf_wdata", 32'(rf_wdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready after reset", 32'(req_ready), 32'd1);

    // Reset during WR_HI of LOAD BC: low half already written, high untouched.
    req_valid = 1'b1; req_op = 2'(OP_LOAD16); req_pair = 2'(PAIR_BC); req_data = 16'hA55A;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("WR_HI load_en", 32'(rf_load_en), 32'd1);
    chk("WR_HI wdata", 32'(rf_wdata), 32'h A5);
    rst = 1'b1;
    #1;
    chk("abort load_en", 32'(rf_load_en), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (5) begin @(negedge clk); if (rsp_valid) seen++; end
    chk("abort no rsp_valid", 32'(seen), 32'd0);
    chk("abort req_ready", 32'(req_ready), 32'd1);
    chk("abort C written", 32'(rf[1]), 32'h 5A);
    chk("abort B kept", 32'(rf[0]), 32'h 00);
    pv[0] = 16'h005A;

    for (int i = 0; i < 9; i++) run_one(tbl[i]);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op, pr;
      op = 2'($urandom_range(3, 0));
      pr = ($urandom_range(7, 0) == 0) ? 2'b11 : 2'($urandom_range(2, 0));
      run_one(model(op, pr, 16'($urandom)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
